// File: rtl/tx_buffer_sender_if.sv
// Control, TX-buffer read port and UART byte handshake of tx_buffer_sender.
// The master modport is the sender; the slave modport is its environment.
interface tx_buffer_sender_if #(
    parameter int AW = 8
);
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_tx_addr;
    logic [7:0]    rd_tx_data;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          byte_ready;

    modport master (
        input  start, start_addr, length, rd_tx_data, byte_ready,
        output busy, done, rd_tx_addr, byte_data, byte_valid
    );

    modport slave (
        output start, start_addr, length, rd_tx_data, byte_ready,
        input  busy, done, rd_tx_addr, byte_data, byte_valid
    );
endinterface

// File: rtl/tx_buffer_sender.sv
// Streams a frame from the TX buffer RAM to the UART over a valid/ready byte port.
// Optional trailing two's-complement checksum byte when TX_CHECKSUM_EN is defined.
module tx_buffer_sender #(
    parameter int NUMBER = 256
) (
    input  logic                clock,
    input  logic                reset,
    tx_buffer_sender_if.master  bus
);
    localparam int AW = (NUMBER > 1) ? $clog2(NUMBER) : 1;

    localparam logic [AW:0]   MAX_LEN  = (AW + 1)'(NUMBER);
    localparam logic [AW:0]   LAST     = (AW + 1)'(1);
    localparam logic [AW-1:0] TOP_ADDR = AW'(NUMBER - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND,
`ifdef TX_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t        state;
    logic          busy_r;
    logic          done_r;
    logic          valid_r;
    logic [7:0]    data_r;
    logic [AW-1:0] addr_r;
    logic [AW:0]   remaining;
`ifdef TX_CHECKSUM_EN
    logic [7:0]    acc;
`endif

    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // Explicit wrap so non-power-of-two depths also return to 0.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        return (a == TOP_ADDR) ? '0 : a + 1'b1;
    endfunction

`ifdef TX_CHECKSUM_EN
    function automatic logic [7:0] csum_byte(input logic [7:0] sum);
        return 8'(~sum + 8'd1);
    endfunction
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            valid_r   <= 1'b0;
            data_r    <= 8'h00;
            addr_r    <= '0;
            remaining <= '0;
`ifdef TX_CHECKSUM_EN
            acc       <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_r    <= bus.start_addr;
                        remaining <= clamp_len(bus.length);
                        busy_r    <= 1'b1;
`ifdef TX_CHECKSUM_EN
                        acc       <= 8'h00;
`endif
                        state     <= (clamp_len(bus.length) == '0) ? DONE : FETCH;
                    end
                end

                FETCH: begin
                    state <= LOAD;
                end

                LOAD: begin
                    data_r  <= bus.rd_tx_data;
                    valid_r <= 1'b1;
`ifdef TX_CHECKSUM_EN
                    acc     <= acc + bus.rd_tx_data;
`endif
                    state   <= SEND;
                end

                SEND: begin
                    if (valid_r && bus.byte_ready) begin
                        remaining <= remaining - LAST;
                        addr_r    <= next_addr(addr_r);
                        if (remaining != LAST) begin
                            valid_r <= 1'b0;
                            state   <= FETCH;
                        end else begin
`ifdef TX_CHECKSUM_EN
                            // Checksum follows immediately; valid stays high.
                            data_r <= csum_byte(acc);
                            state  <= CSUM;
`else
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= DONE;
`endif
                        end
                    end
                end

`ifdef TX_CHECKSUM_EN
                CSUM: begin
                    if (valid_r && bus.byte_ready) begin
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end
                end
`endif

                // Entered with done already set after a transfer, or clear for an empty frame.
                DONE: begin
                    if (done_r) begin
                        done_r <= 1'b0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        done_r <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.byte_valid = valid_r;
    assign bus.byte_data  = data_r;
    assign bus.rd_tx_addr = addr_r;

endmodule

// File: tb/tb_tx_buffer_sender.sv
// Directed bench for tx_buffer_sender with a registered-output RAM model.
module tb_tx_buffer_sender;
`ifdef TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    logic [7:0] mem [256];

    tx_buffer_sender_if #(.AW(8)) bus ();

    tx_buffer_sender #(.NUMBER(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) bus.rd_tx_data <= mem[bus.rd_tx_addr];

    logic [7:0] byte_q [$];
    logic [7:0] addr_q [$];
    int         xfer_q [$];
    int         rise_q [$];
    int         done_q [$];
    int         busy_cnt = 0;
    logic       prev_valid = 1'b0;

    always @(negedge clock) begin
        if (bus.byte_valid && !prev_valid) rise_q.push_back(cyc);
        prev_valid = bus.byte_valid;
        if (bus.byte_valid && bus.byte_ready && !reset) begin
            byte_q.push_back(bus.byte_data);
            addr_q.push_back(bus.rd_tx_addr);
            xfer_q.push_back(cyc);
        end
        if (bus.done) done_q.push_back(cyc);
        if (bus.busy) busy_cnt++;
    end

    task automatic start_frame(input logic [7:0] addr, input logic [8:0] len, output int start_edge);
        @(posedge clock); #1;
        bus.start      = 1'b1;
        bus.start_addr = addr;
        bus.length     = len;
        start_edge     = cyc + 1;
        @(posedge clock); #1;
        bus.start      = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, output bit timed_out);
        int n;
        n = 0;
        while (done_q.size() == d0 && n < limit) begin
            @(posedge clock);
            n++;
        end
        timed_out = (done_q.size() == d0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests++; if (bus.byte_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.byte_valid); end
        tests++; if (bus.byte_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", bus.byte_data); end
        tests++; if (bus.rd_tx_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got %h want 00", bus.rd_tx_addr); end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        int n0, r0, d0, x0, se;
        bit to;
        exp = '{8'h01, 8'h02, 8'h03};
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        n0 = byte_q.size(); r0 = rise_q.size(); d0 = done_q.size(); x0 = xfer_q.size();
        bus.byte_ready = 1'b1;
        start_frame(8'h00, 9'd3, se);
        wait_done(d0, 100, to);
        tests++; if (to) begin fails++; $display("FAIL basic_timeout got no done want done"); end
        tests++; if (byte_q.size() - n0 != 3 + CS) begin fails++; $display("FAIL basic_count got %0d want %0d", byte_q.size() - n0, 3 + CS); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (byte_q[n0 + i] !== exp[i]) begin fails++; $display("FAIL basic_byte%0d got %h want %h", i, byte_q[n0 + i], exp[i]); end
            end
`ifdef TX_CHECKSUM_EN
            tests++; if (byte_q[n0 + 3] !== 8'hFA) begin fails++; $display("FAIL basic_csum got %h want fa", byte_q[n0 + 3]); end
`endif
            tests++; if (xfer_q[x0 + 1] - xfer_q[x0] != 3) begin fails++; $display("FAIL basic_rate got %0d want 3", xfer_q[x0 + 1] - xfer_q[x0]); end
            tests++; if (done_q.size() > d0 && done_q[d0] != xfer_q[x0 + 2 + CS] + 1) begin fails++; $display("FAIL basic_done_lat got %0d want %0d", done_q[d0], xfer_q[x0 + 2 + CS] + 1); end
        end
        tests++; if (rise_q.size() <= r0 || rise_q[r0] - se != 2) begin fails++; $display("FAIL basic_first_valid got %0d want 2", (rise_q.size() > r0) ? rise_q[r0] - se : -1); end
        tests++; if (done_q.size() - d0 != 1) begin fails++; $display("FAIL basic_done_cnt got %0d want 1", done_q.size() - d0); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4];
        int n0, d0, se;
        bit to;
        exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;
        n0 = byte_q.size(); d0 = done_q.size();
        bus.byte_ready = 1'b1;
        start_frame(8'hFE, 9'd4, se);
        wait_done(d0, 100, to);
        tests++; if (to) begin fails++; $display("FAIL wrap_timeout got no done want done"); end
        tests++; if (byte_q.size() - n0 != 4 + CS) begin fails++; $display("FAIL wrap_count got %0d want %0d", byte_q.size() - n0, 4 + CS); end
        else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (byte_q[n0 + i] !== exp[i]) begin fails++; $display("FAIL wrap_byte%0d got %h want %h", i, byte_q[n0 + i], exp[i]); end
            end
            tests++; if (addr_q[n0 + 2] !== 8'h00) begin fails++; $display("FAIL wrap_addr got %h want 00", addr_q[n0 + 2]); end
`ifdef TX_CHECKSUM_EN
            tests++; if (byte_q[n0 + 4] !== 8'hF2) begin fails++; $display("FAIL wrap_csum got %h want f2", byte_q[n0 + 4]); end
`endif
        end
        tests++; if (bus.rd_tx_addr !== 8'h02) begin fails++; $display("FAIL wrap_final_addr got %h want 02", bus.rd_tx_addr); end
    endtask

    task automatic test_stall();
        logic [7:0] exp [4];
        int n0, d0, se, n;
        bit to;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) mem[8'h10 + i] = exp[i];
        n0 = byte_q.size(); d0 = done_q.size();
        bus.byte_ready = 1'b1;
        start_frame(8'h10, 9'd4, se);
        n = 0;
        while (byte_q.size() - n0 < 1 && n < 20) begin @(posedge clock); #1; n++; end
        bus.byte_ready = 1'b0;
        n = 0;
        @(negedge clock);
        while (!bus.byte_valid && n < 20) begin @(negedge clock); n++; end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (bus.byte_valid !== 1'b1 || bus.byte_data !== 8'h22) begin
                fails++; $display("FAIL stall_hold%0d got v=%b d=%h want v=1 d=22", i, bus.byte_valid, bus.byte_data);
            end
            @(negedge clock);
        end
        @(posedge clock); #1;
        bus.byte_ready = 1'b1;
        wait_done(d0, 100, to);
        tests++; if (to) begin fails++; $display("FAIL stall_timeout got no done want done"); end
        tests++; if (byte_q.size() - n0 != 4 + CS) begin fails++; $display("FAIL stall_count got %0d want %0d", byte_q.size() - n0, 4 + CS); end
        else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (byte_q[n0 + i] !== exp[i]) begin fails++; $display("FAIL stall_byte%0d got %h want %h", i, byte_q[n0 + i], exp[i]); end
            end
        end
    endtask

    task automatic test_zero_len();
        int n0, r0, d0, b0, se;
        bit to;
        n0 = byte_q.size(); r0 = rise_q.size(); d0 = done_q.size(); b0 = busy_cnt;
        bus.byte_ready = 1'b1;
        start_frame(8'h05, 9'd0, se);
        wait_done(d0, 20, to);
        tests++; if (to) begin fails++; $display("FAIL zero_timeout got no done want done"); end
        tests++; if (rise_q.size() != r0) begin fails++; $display("FAIL zero_valid got %0d rises want 0", rise_q.size() - r0); end
        tests++; if (byte_q.size() != n0) begin fails++; $display("FAIL zero_bytes got %0d want 0", byte_q.size() - n0); end
        tests++; if (busy_cnt - b0 != 2) begin fails++; $display("FAIL zero_busy got %0d cycles want 2", busy_cnt - b0); end
        tests++; if (done_q.size() - d0 != 1) begin fails++; $display("FAIL zero_done got %0d want 1", done_q.size() - d0); end
    endtask

    task automatic test_clamp();
        int n0, d0, se, errs;
        bit to;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        n0 = byte_q.size(); d0 = done_q.size();
        bus.byte_ready = 1'b1;
        start_frame(8'h00, 9'd300, se);
        wait_done(d0, 1200, to);
        tests++; if (to) begin fails++; $display("FAIL clamp_timeout got no done want done"); end
        tests++; if (byte_q.size() - n0 != 256 + CS) begin fails++; $display("FAIL clamp_count got %0d want %0d", byte_q.size() - n0, 256 + CS); end
        else begin
            errs = 0;
            for (int i = 0; i < 256; i++) if (byte_q[n0 + i] !== (8'(i) ^ 8'h5A)) errs++;
            tests++; if (errs != 0) begin fails++; $display("FAIL clamp_content got %0d wrong bytes want 0", errs); end
`ifdef TX_CHECKSUM_EN
            tests++; if (byte_q[n0 + 256] !== 8'h80) begin fails++; $display("FAIL clamp_csum got %h want 80", byte_q[n0 + 256]); end
`endif
        end
    endtask

    task automatic test_restart_ignored();
        logic [7:0] exp [3];
        int n0, r0, d0, se, se2, n;
        bit to;
        exp = '{8'h31, 8'h32, 8'h33};
        for (int i = 0; i < 3; i++) mem[8'h20 + i] = exp[i];
        for (int i = 0; i < 5; i++) mem[8'h80 + i] = 8'hE0 + 8'(i);
        n0 = byte_q.size(); r0 = rise_q.size(); d0 = done_q.size();
        bus.byte_ready = 1'b1;
        start_frame(8'h20, 9'd3, se);
        n = 0;
        while (byte_q.size() - n0 < 1 && n < 20) begin @(posedge clock); #1; n++; end
        start_frame(8'h80, 9'd5, se2);
        wait_done(d0, 100, to);
        repeat (30) @(posedge clock);
        #1;
        tests++; if (to) begin fails++; $display("FAIL restart_timeout got no done want done"); end
        tests++; if (byte_q.size() - n0 != 3 + CS) begin fails++; $display("FAIL restart_count got %0d want %0d", byte_q.size() - n0, 3 + CS); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (byte_q[n0 + i] !== exp[i]) begin fails++; $display("FAIL restart_byte%0d got %h want %h", i, byte_q[n0 + i], exp[i]); end
            end
        end
        tests++; if (rise_q.size() - r0 != 3) begin fails++; $display("FAIL restart_rises got %0d want 3", rise_q.size() - r0); end
        tests++; if (done_q.size() - d0 != 1) begin fails++; $display("FAIL restart_done got %0d want 1", done_q.size() - d0); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL restart_busy_end got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [3];
        int n0, d0, se, n;
        bit to;
        exp = '{8'h77, 8'h78, 8'h79};
        for (int i = 0; i < 3; i++) mem[8'h40 + i] = exp[i];
        n0 = byte_q.size();
        bus.byte_ready = 1'b0;
        start_frame(8'h40, 9'd3, se);
        n = 0;
        @(negedge clock);
        while (!bus.byte_valid && n < 20) begin @(negedge clock); n++; end
        tests++; if (bus.byte_valid !== 1'b1) begin fails++; $display("FAIL rstmid_valid_before got %b want 1", bus.byte_valid); end
        #2;
        reset = 1'b1;
        #1;
        tests++; if (bus.byte_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b want 0", bus.byte_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        tests++; if (bus.byte_data !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h want 00", bus.byte_data); end
        tests++; if (bus.rd_tx_addr !== 8'h00) begin fails++; $display("FAIL rstmid_addr got %h want 00", bus.rd_tx_addr); end
        @(posedge clock); #1;
        reset = 1'b0;
        bus.byte_ready = 1'b1;
        d0 = done_q.size();
        start_frame(8'h40, 9'd3, se);
        wait_done(d0, 100, to);
        tests++; if (to) begin fails++; $display("FAIL rstmid_timeout got no done want done"); end
        tests++; if (byte_q.size() - n0 != 3 + CS) begin fails++; $display("FAIL rstmid_count got %0d want %0d", byte_q.size() - n0, 3 + CS); end
        else begin
            for (int i = 0; i < 3; i++) begin
                tests++; if (byte_q[n0 + i] !== exp[i]) begin fails++; $display("FAIL rstmid_byte%0d got %h want %h", i, byte_q[n0 + i], exp[i]); end
            end
`ifdef TX_CHECKSUM_EN
            tests++; if (byte_q[n0 + 3] !== 8'h98) begin fails++; $display("FAIL rstmid_csum got %h want 98", byte_q[n0 + 3]); end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.start      = 1'b0;
        bus.start_addr = 8'h00;
        bus.length     = 9'd0;
        bus.byte_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_stall();
        test_zero_len();
        test_clamp();
        test_restart_ignored();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
